// File: rtl/alu_seq_arbiter.sv
// rtl/alu_seq_arbiter.sv - two-port arbiter/sequencer driving a registered ALU
//
// Purpose:
//   Accepts ALU operation requests from two requesters over valid/ready and
//   grants one at a time. It sequences the ALU through an issue cycle and a
//   capture cycle, then returns the result and flags on a single response
//   channel tagged with the requester ID. Illegal opcodes are answered
//   immediately with an error response, and the ALU is never enabled for them.
//
// Configuration macro:
//   ALU_SEQ_FIXED_PRIO_EN - when defined, requester 0 always wins when both
//                           requesters are valid, and no round-robin pointer
//                           exists. When undefined, arbitration is round-robin.
//
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   REQx_VALID / REQx_READY      request handshake for requester x (0/1)
//   REQx_OPCODE, REQx_A, REQx_B  request opcode and operands
//   RSP_VALID / RSP_READY        response handshake
//   RSP_ID, RSP_ERR              issuing requester, illegal-opcode flag
//   RSP_DATA, RSP_FLAGS          captured result and {CF,OF,SF,ZF}
//   ALU_EN, ALU_OE               ALU controls
//   ALU_OPCODE, ALU_A, ALU_B     ALU opcode and operands
//   ALU_OUT, ALU_CF/OF/SF/ZF     ALU result and flags

module alu_seq_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,

    input  logic             REQ0_VALID,
    output logic             REQ0_READY,
    input  logic [3:0]       REQ0_OPCODE,
    input  logic [WIDTH-1:0] REQ0_A,
    input  logic [WIDTH-1:0] REQ0_B,

    input  logic             REQ1_VALID,
    output logic             REQ1_READY,
    input  logic [3:0]       REQ1_OPCODE,
    input  logic [WIDTH-1:0] REQ1_A,
    input  logic [WIDTH-1:0] REQ1_B,

    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic             RSP_ID,
    output logic             RSP_ERR,
    output logic [WIDTH-1:0] RSP_DATA,
    output logic [3:0]       RSP_FLAGS,

    output logic             ALU_EN,
    output logic             ALU_OE,
    output logic [3:0]       ALU_OPCODE,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    input  logic [WIDTH-1:0] ALU_OUT,
    input  logic             ALU_CF,
    input  logic             ALU_OF,
    input  logic             ALU_SF,
    input  logic             ALU_ZF
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state;

    // ADD..NOT occupy 0010..0111.
    function automatic logic is_legal(input logic [3:0] op);
        return (op >= 4'b0010) && (op <= 4'b0111);
    endfunction

    // AND/OR/XOR/NOT leave the ALU carry and overflow untouched.
    function automatic logic is_logic_op(input logic [3:0] op);
        return (op >= 4'b0100) && (op <= 4'b0111);
    endfunction

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic             win1;
    logic             can_accept;
    logic             accept;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

`ifdef ALU_SEQ_FIXED_PRIO_EN
    // Requester 1 only wins when requester 0 is idle.
    assign win1 = REQ1_VALID && !REQ0_VALID;
`else
    logic rr_ptr;   // requester that has priority for the next grant

    // Pointer at 1: requester 1 wins whenever it is valid.
    // Pointer at 0: requester 1 wins only when requester 0 is idle.
    assign win1 = rr_ptr ? REQ1_VALID : (REQ1_VALID && !REQ0_VALID);
`endif

    // Ready is combinational in IDLE. It is masked during reset so that every
    // output reads 0 while RST is asserted.
    assign can_accept = (state == IDLE) && !RST;
    assign REQ1_READY = can_accept && win1;
    assign REQ0_READY = can_accept && REQ0_VALID && !win1;
    assign accept     = REQ0_READY || REQ1_READY;

    assign sel_op = win1 ? REQ1_OPCODE : REQ0_OPCODE;
    assign sel_a  = win1 ? REQ1_A      : REQ0_A;
    assign sel_b  = win1 ? REQ1_B      : REQ0_B;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    // ALU_OPCODE/A/B double as the latched command. They are loaded only for
    // legal opcodes, so they keep the last issued values through RESP and
    // across illegal requests.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            RSP_VALID  <= 1'b0;
            RSP_ID     <= 1'b0;
            RSP_ERR    <= 1'b0;
            RSP_DATA   <= '0;
            RSP_FLAGS  <= 4'b0000;
            ALU_EN     <= 1'b0;
            ALU_OE     <= 1'b0;
            ALU_OPCODE <= 4'b0000;
            ALU_A      <= '0;
            ALU_B      <= '0;
`ifndef ALU_SEQ_FIXED_PRIO_EN
            rr_ptr     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        RSP_ID <= win1;
`ifndef ALU_SEQ_FIXED_PRIO_EN
                        rr_ptr <= !win1;
`endif
                        if (is_legal(sel_op)) begin
                            ALU_EN     <= 1'b1;
                            ALU_OE     <= 1'b0;
                            ALU_OPCODE <= sel_op;
                            ALU_A      <= sel_a;
                            ALU_B      <= sel_b;
                            RSP_ERR    <= 1'b0;
                            state      <= ISSUE;
                        end else begin
                            // Error response straight away; the ALU is untouched.
                            RSP_ERR   <= 1'b1;
                            RSP_DATA  <= '0;
                            RSP_FLAGS <= 4'b0000;
                            RSP_VALID <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end

                ISSUE: begin
                    // The ALU registers the result at this edge. Keep EN high
                    // for one more cycle so that the recomputed value and the
                    // operand-dependent OF flag remain valid while OE is on.
                    ALU_OE <= 1'b1;
                    state  <= CAPTURE;
                end

                CAPTURE: begin
                    RSP_DATA <= ALU_OUT;
                    if (is_logic_op(ALU_OPCODE)) begin
                        RSP_FLAGS <= {2'b00, ALU_SF, ALU_ZF};
                    end else begin
                        RSP_FLAGS <= {ALU_CF, ALU_OF, ALU_SF, ALU_ZF};
                    end
                    RSP_VALID <= 1'b1;
                    ALU_EN    <= 1'b0;
                    ALU_OE    <= 1'b0;
                    state     <= RESP;
                end

                RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
